core_lsu: RTL

- Load/store execution stage directly downstream of the decoder cascade's preempt channel.
- Accepts one memory request per issue: load, store, load indirect or store indirect. Runs the request against data memory, or against TOY stdin/stdout at IO_ADDR.
- For loads, writes the result back to the register file.
- Holds busy_o high for the whole access; the cascade's stall is released only when busy_o drops.

---
 rtl/core_lsu.sv | 118 +++++++++++
 1 files changed

// File: rtl/core_lsu.sv
// Load/store execution stage: runs one load/store per issue against data memory,
// or against stdin/stdout when the address hits IO_ADDR.
module core_lsu #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 16,
  parameter logic [ADDR_W-1:0] IO_ADDR = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_en_i,
  input  logic              req_wen_i,
  input  logic              req_kind_i,
  input  logic [3:0]        req_rd_i,
  input  logic [ADDR_W-1:0] req_imm_i,
  input  logic [DATA_W-1:0] req_rt_i,
  input  logic [DATA_W-1:0] req_rd_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              stdin_valid_i,
  input  logic [DATA_W-1:0] stdin_data_i,
  output logic              stdin_ready_o,
  output logic              stdout_valid_o,
  output logic [DATA_W-1:0] stdout_data_o,
  input  logic              stdout_ready_i,
  output logic              wb_en_o,
  output logic [3:0]        wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_REQ, S_MEM_WAIT, S_IO_IN, S_IO_OUT, S_WB, S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [3:0]        rd_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] req_addr;
  logic              unused_rt_hi;

  assign req_addr     = req_kind_i ? req_imm_i : req_rt_i[ADDR_W-1:0];
  assign unused_rt_hi = ^req_rt_i[DATA_W-1:ADDR_W];

  // data_q holds the store word on the way out and the loaded word on the way back
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_en_i) begin
            addr_q <= req_addr;
            wen_q  <= req_wen_i;
            rd_q   <= req_rd_i;
            data_q <= req_rd_data_i;
            if (req_addr == IO_ADDR) state_q <= req_wen_i ? S_IO_OUT : S_IO_IN;
            else                     state_q <= S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          if (mem_gnt_i) begin
            if (wen_q) begin
              state_q <= S_DONE;
            end else if (mem_rvalid_i) begin
              data_q  <= mem_rdata_i;
              state_q <= S_WB;
            end else begin
              state_q <= S_MEM_WAIT;
            end
          end
        end
        S_MEM_WAIT: begin
          if (mem_rvalid_i) begin
            data_q  <= mem_rdata_i;
            state_q <= S_WB;
          end
        end
        S_IO_IN: begin
          if (stdin_valid_i) begin
            data_q  <= stdin_data_i;
            state_q <= S_WB;
          end
        end
        S_IO_OUT: if (stdout_ready_i) state_q <= S_DONE;
        S_WB:     state_q <= S_IDLE;
        S_DONE:   state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the registered state; data buses are gated to zero outside their phase
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_WB) || (state_q == S_DONE);
  assign mem_req_o      = (state_q == S_MEM_REQ);
  assign mem_we_o       = mem_req_o && wen_q;
  assign mem_addr_o     = mem_req_o ? addr_q : '0;
  assign mem_wdata_o    = (mem_req_o && wen_q) ? data_q : '0;
  assign stdin_ready_o  = (state_q == S_IO_IN);
  assign stdout_valid_o = (state_q == S_IO_OUT);
  assign stdout_data_o  = stdout_valid_o ? data_q : '0;
  assign wb_en_o        = (state_q == S_WB) && (rd_q != 4'd0);
  assign wb_addr_o      = (state_q == S_WB) ? rd_q : 4'd0;
  assign wb_data_o      = (state_q == S_WB) ? data_q : '0;

endmodule
